// File: rtl/pipelined_dual_port_blockram_pkg.sv
// Shared constants for the pipelined dual-port block RAM: byte size and the
// encodings of the write-collision return mode.
package pipelined_dual_port_blockram_pkg;

    localparam int BYTE_LEN_IN_BITS       = 8;
    localparam int WRITE_MODE_READ_FIRST  = 0;
    localparam int WRITE_MODE_WRITE_FIRST = 1;

endpackage

// File: rtl/pipelined_dual_port_blockram_read_pipeline.sv
// Per-port read return pipeline: shifts valid/data READ_LATENCY stages and
// holds the last returned entry on the output while no new data arrives.
module blockram_read_pipeline
    import pipelined_dual_port_blockram_pkg::*;
#(
    parameter int WIDTH        = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data
);

    logic [READ_LATENCY-1:0] r_vld_p;
    logic [WIDTH-1:0]        r_data_p [READ_LATENCY];

    // Data stages only load behind a valid, so the last stage doubles as the output hold register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_p                    <= '0;
            r_data_p[READ_LATENCY-1]   <= '0;
        end else begin
            r_vld_p[0] <= i_vld;
            if (i_vld) begin
                r_data_p[0] <= i_data;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_vld_p[k] <= r_vld_p[k-1];
                if (r_vld_p[k-1]) begin
                    r_data_p[k] <= r_data_p[k-1];
                end
            end
        end
    end

    assign o_vld  = r_vld_p[READ_LATENCY-1];
    assign o_data = r_data_p[READ_LATENCY-1];

endmodule

// File: rtl/pipelined_dual_port_blockram.sv
// True dual-port block RAM with byte-masked writes, configurable read latency
// and deterministic same-address collision behaviour (port A wins per byte).
module pipelined_dual_port_blockram
    import pipelined_dual_port_blockram_pkg::*;
#(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET                   = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS,
    parameter int READ_LATENCY              = 1,
    parameter int WRITE_MODE                = WRITE_MODE_READ_FIRST
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    input  logic                                 port_A_access_en_in,
    input  logic [WRITE_MASK_LEN-1:0]            port_A_write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     port_A_access_set_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] port_A_write_entry_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] port_A_read_entry_out,
    output logic                                 port_A_read_valid_out,
    input  logic                                 port_B_access_en_in,
    input  logic [WRITE_MASK_LEN-1:0]            port_B_write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     port_B_access_set_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] port_B_write_entry_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] port_B_read_entry_out,
    output logic                                 port_B_read_valid_out,
    output logic                                 collision_out
);

    localparam int W  = SINGLE_ENTRY_SIZE_IN_BITS;
    localparam int AW = SET_PTR_WIDTH_IN_BITS;
    localparam int BL = BYTE_LEN_IN_BITS;
    localparam logic [AW:0] NUM_SET_W = (AW+1)'(NUM_SET);

    logic [W-1:0] r_mem [NUM_SET];
    logic         r_collision;

    logic         w_a_en, w_b_en, w_a_in_range, w_b_in_range;
    logic         w_a_wr, w_b_wr, w_same_addr;
    logic [W-1:0] w_a_old, w_b_old, w_a_new, w_b_new, w_a_ret, w_b_ret;

    assign w_a_en       = port_A_access_en_in & ~reset_in;
    assign w_b_en       = port_B_access_en_in & ~reset_in;
    assign w_a_in_range = {1'b0, port_A_access_set_addr_in} < NUM_SET_W;
    assign w_b_in_range = {1'b0, port_B_access_set_addr_in} < NUM_SET_W;
    assign w_a_wr       = w_a_en & w_a_in_range & (|port_A_write_en_in);
    assign w_b_wr       = w_b_en & w_b_in_range & (|port_B_write_en_in);
    assign w_same_addr  = w_a_en & w_b_en &
                          (port_A_access_set_addr_in == port_B_access_set_addr_in);

    assign w_a_old = w_a_in_range ? r_mem[port_A_access_set_addr_in] : '0;
    assign w_b_old = w_b_in_range ? r_mem[port_B_access_set_addr_in] : '0;

    // Both merged values describe the entry after this edge; on a shared address they are identical.
    always_comb begin
        w_a_new = w_a_old;
        w_b_new = w_b_old;
        for (int i = 0; i < WRITE_MASK_LEN; i++) begin
            if (w_same_addr && w_b_wr && port_B_write_en_in[i]) begin
                w_a_new[i*BL +: BL] = port_B_write_entry_in[i*BL +: BL];
            end
            if (w_a_wr && port_A_write_en_in[i]) begin
                w_a_new[i*BL +: BL] = port_A_write_entry_in[i*BL +: BL];
            end
            if (w_b_wr && port_B_write_en_in[i]) begin
                w_b_new[i*BL +: BL] = port_B_write_entry_in[i*BL +: BL];
            end
            if (w_same_addr && w_a_wr && port_A_write_en_in[i]) begin
                w_b_new[i*BL +: BL] = port_A_write_entry_in[i*BL +: BL];
            end
        end
    end

    assign w_a_ret = (WRITE_MODE == WRITE_MODE_WRITE_FIRST) ? w_a_new : w_a_old;
    assign w_b_ret = (WRITE_MODE == WRITE_MODE_WRITE_FIRST) ? w_b_new : w_b_old;

    always_ff @(posedge clk_in) begin
        if (w_b_wr) begin
            r_mem[port_B_access_set_addr_in] <= w_b_new;
        end
        if (w_a_wr) begin
            r_mem[port_A_access_set_addr_in] <= w_a_new;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= w_same_addr & ((|port_A_write_en_in) | (|port_B_write_en_in));
        end
    end

    assign collision_out = r_collision;

    blockram_read_pipeline #(
        .WIDTH        (W),
        .READ_LATENCY (READ_LATENCY)
    ) u_read_pipe_a (
        .i_clk  (clk_in),
        .i_rst  (reset_in),
        .i_vld  (w_a_en),
        .i_data (w_a_ret),
        .o_vld  (port_A_read_valid_out),
        .o_data (port_A_read_entry_out)
    );

    blockram_read_pipeline #(
        .WIDTH        (W),
        .READ_LATENCY (READ_LATENCY)
    ) u_read_pipe_b (
        .i_clk  (clk_in),
        .i_rst  (reset_in),
        .i_vld  (w_b_en),
        .i_data (w_b_ret),
        .o_vld  (port_B_read_valid_out),
        .o_data (port_B_read_entry_out)
    );

endmodule

// File: tb/tb_pipelined_dual_port_blockram.sv
// Bench for pipelined_dual_port_blockram: two instances (latency 1 read-first,
// latency 3 write-first) driven identically and compared with an array model.
module tb_pipelined_dual_port_blockram;

    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_en = 1'b0, b_en = 1'b0;
    logic [7:0]  a_we = '0, b_we = '0;
    logic [5:0]  a_addr = '0, b_addr = '0;
    logic [63:0] a_wd = '0, b_wd = '0;

    logic [63:0] a0_rd, b0_rd, a1_rd, b1_rd;
    logic        a0_v, b0_v, a1_v, b1_v, col0, col1;

    always #5 clk = ~clk;

    pipelined_dual_port_blockram #(.READ_LATENCY(1), .WRITE_MODE(0)) dut0 (
        .clk_in(clk), .reset_in(rst),
        .port_A_access_en_in(a_en), .port_A_write_en_in(a_we),
        .port_A_access_set_addr_in(a_addr), .port_A_write_entry_in(a_wd),
        .port_A_read_entry_out(a0_rd), .port_A_read_valid_out(a0_v),
        .port_B_access_en_in(b_en), .port_B_write_en_in(b_we),
        .port_B_access_set_addr_in(b_addr), .port_B_write_entry_in(b_wd),
        .port_B_read_entry_out(b0_rd), .port_B_read_valid_out(b0_v),
        .collision_out(col0)
    );

    pipelined_dual_port_blockram #(.READ_LATENCY(3), .WRITE_MODE(1)) dut1 (
        .clk_in(clk), .reset_in(rst),
        .port_A_access_en_in(a_en), .port_A_write_en_in(a_we),
        .port_A_access_set_addr_in(a_addr), .port_A_write_entry_in(a_wd),
        .port_A_read_entry_out(a1_rd), .port_A_read_valid_out(a1_v),
        .port_B_access_en_in(b_en), .port_B_write_en_in(b_we),
        .port_B_access_set_addr_in(b_addr), .port_B_write_entry_in(b_wd),
        .port_B_read_entry_out(b1_rd), .port_B_read_valid_out(b1_v),
        .collision_out(col1)
    );

    // dout[instance][port]
    logic [63:0] dout [2][2];
    logic        dvld [2][2];
    logic        dcol [2];
    assign dout[0][0] = a0_rd; assign dout[0][1] = b0_rd;
    assign dout[1][0] = a1_rd; assign dout[1][1] = b1_rd;
    assign dvld[0][0] = a0_v;  assign dvld[0][1] = b0_v;
    assign dvld[1][0] = a1_v;  assign dvld[1][1] = b1_v;
    assign dcol[0] = col0;     assign dcol[1] = col1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 50)
                $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Model: per sampling edge, record what each port must return and whether a collision occurred.
    logic [63:0] mem [64];
    bit          mk  [64];
    bit          h_rst [MAXC];
    bit          h_col [MAXC];
    bit          h_vld [2][MAXC];
    logic [63:0] h_old [2][MAXC];
    logic [63:0] h_new [2][MAXC];
    bit          h_ko  [2][MAXC];
    bit          h_kn  [2][MAXC];
    bit          m_en [2];
    logic [7:0]  m_we [2];
    logic [5:0]  m_ad [2];
    logic [63:0] m_wd [2];

    always @(posedge clk) begin
        cyc++;
        if (cyc < MAXC) begin
            m_en[0] = a_en; m_we[0] = a_we; m_ad[0] = a_addr; m_wd[0] = a_wd;
            m_en[1] = b_en; m_we[1] = b_we; m_ad[1] = b_addr; m_wd[1] = b_wd;
            h_rst[cyc] = rst;
            h_col[cyc] = 1'b0;
            for (int p = 0; p < 2; p++) h_vld[p][cyc] = !rst && m_en[p];
            if (!rst) begin
                for (int p = 0; p < 2; p++) begin
                    h_old[p][cyc] = mem[m_ad[p]];
                    h_ko[p][cyc]  = mk[m_ad[p]];
                end
                // B first, then A, so A's bytes win on a shared address.
                for (int p = 1; p >= 0; p--) begin
                    if (m_en[p] && m_we[p] != 8'h00) begin
                        for (int b = 0; b < 8; b++)
                            if (m_we[p][b]) mem[m_ad[p]][8*b +: 8] = m_wd[p][8*b +: 8];
                        if (m_we[p] == 8'hFF) mk[m_ad[p]] = 1'b1;
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    h_new[p][cyc] = mem[m_ad[p]];
                    h_kn[p][cyc]  = mk[m_ad[p]];
                end
                h_col[cyc] = m_en[0] && m_en[1] && (m_ad[0] == m_ad[1]) &&
                             ((m_we[0] | m_we[1]) != 8'h00);
            end
        end
    end

    logic [63:0] ehold [2][2];
    bit          ehk   [2][2];

    always @(negedge clk) begin
        if (cyc > 0 && cyc < MAXC) begin
            for (int i = 0; i < 2; i++) begin
                int rl;
                rl = (i == 0) ? 1 : 3;
                for (int p = 0; p < 2; p++) begin
                    int  n;
                    bit  ev;
                    n  = cyc - rl + 1;
                    ev = 1'b0;
                    if (!h_rst[cyc] && n >= 1 && h_vld[p][n]) begin
                        ev = 1'b1;
                        for (int e = n + 1; e <= cyc; e++) if (h_rst[e]) ev = 1'b0;
                    end
                    if (h_rst[cyc]) begin
                        ehold[i][p] = '0;
                        ehk[i][p]   = 1'b1;
                    end else if (ev) begin
                        ehold[i][p] = (i == 1) ? h_new[p][n] : h_old[p][n];
                        ehk[i][p]   = (i == 1) ? h_kn[p][n]  : h_ko[p][n];
                    end
                    check($sformatf("i%0d_p%0d_valid", i, p), 64'(dvld[i][p]), 64'(ev));
                    if (ehk[i][p])
                        check($sformatf("i%0d_p%0d_data", i, p), dout[i][p], ehold[i][p]);
                end
                check($sformatf("i%0d_collision", i), 64'(dcol[i]),
                      64'(h_col[cyc] && !h_rst[cyc]));
            end
        end
    end

    task automatic drive(input bit ae, input logic [7:0] awe, input logic [5:0] aa, input logic [63:0] ad,
                         input bit be, input logic [7:0] bwe, input logic [5:0] ba, input logic [63:0] bd);
        a_en = ae; a_we = awe; a_addr = aa; a_wd = ad;
        b_en = be; b_we = bwe; b_addr = ba; b_wd = bd;
        @(posedge clk);
        #1;
        a_en = 1'b0; b_en = 1'b0; a_we = '0; b_we = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [5:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        return (r < 8) ? 6'(r) : 6'd63;
    endfunction

    function automatic logic [7:0] pick_we();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'($urandom);
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        for (int k = 0; k < 64; k++) mk[k] = 1'b0;
        idle(3);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_i%0d_a_data", i), dout[i][0], 64'h0);
            check($sformatf("rst_i%0d_b_data", i), dout[i][1], 64'h0);
            check($sformatf("rst_i%0d_a_valid", i), 64'(dvld[i][0]), 64'h0);
            check($sformatf("rst_i%0d_col", i), 64'(dcol[i]), 64'h0);
        end
        rst = 1'b0;

        for (int i = 0; i < 32; i++) drive(1, 8'hFF, 6'(i), 64'h0, 1, 8'hFF, 6'(i + 32), 64'h0);
        idle(4);

        drive(1, 8'hFF, 6'd63, 64'hAAAA_AAAA_AAAA_AAAA, 0, 8'h00, 6'd0, 64'h0);
        idle(4);
        check("wr63_ret_i0", dout[0][0], 64'h0);
        check("wr63_ret_i1", dout[1][0], 64'hAAAA_AAAA_AAAA_AAAA);
        drive(1, 8'h00, 6'd63, 64'h0, 0, 8'h00, 6'd0, 64'h0);
        idle(4);
        check("rd63_i0", dout[0][0], 64'hAAAA_AAAA_AAAA_AAAA);
        check("rd63_i1", dout[1][0], 64'hAAAA_AAAA_AAAA_AAAA);

        drive(0, 8'h00, 6'd0, 64'h0, 1, 8'h0F, 6'd1, 64'h1111_2222_3333_4444);
        idle(4);
        drive(0, 8'h00, 6'd0, 64'h0, 1, 8'h00, 6'd1, 64'h0);
        idle(4);
        check("rd1_mask_i0", dout[0][1], 64'h0000_0000_3333_4444);
        check("rd1_mask_i1", dout[1][1], 64'h0000_0000_3333_4444);

        drive(1, 8'hFF, 6'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1, 8'h00, 6'd63, 64'h0);
        idle(4);
        check("b_rd63_i0", dout[0][1], 64'hAAAA_AAAA_AAAA_AAAA);
        check("b_rd63_i1", dout[1][1], 64'hAAAA_AAAA_AAAA_AAAA);
        drive(1, 8'h00, 6'd3, 64'h0, 0, 8'h00, 6'd0, 64'h0);
        idle(4);
        check("rd3_i0", dout[0][0], 64'hFFFF_FFFF_FFFF_FFFF);
        check("rd3_i1", dout[1][0], 64'hFFFF_FFFF_FFFF_FFFF);

        drive(1, 8'hF0, 6'd5, 64'hAAAA_AAAA_AAAA_AAAA, 1, 8'hFF, 6'd5, 64'hBBBB_BBBB_BBBB_BBBB);
        check("coll_pulse_i0", 64'(dcol[0]), 64'h1);
        check("coll_pulse_i1", 64'(dcol[1]), 64'h1);
        check("model_mem5", mem[5], 64'hAAAA_AAAA_BBBB_BBBB);
        idle(4);
        drive(1, 8'h00, 6'd5, 64'h0, 0, 8'h00, 6'd0, 64'h0);
        idle(4);
        check("rd5_i0", dout[0][0], 64'hAAAA_AAAA_BBBB_BBBB);
        check("rd5_i1", dout[1][0], 64'hAAAA_AAAA_BBBB_BBBB);

        drive(1, 8'hFF, 6'd7, 64'h5, 1, 8'h00, 6'd7, 64'h0);
        idle(4);
        check("wr_rd7_i0", dout[0][1], 64'h0);
        check("wr_rd7_i1", dout[1][1], 64'h5);

        for (int i = 0; i < 8; i++) begin
            rst = (i == 4 || i == 5);
            drive(1, 8'h00, 6'(i), 64'h0, rst, 8'hFF, 6'd3, 64'h0);
        end
        rst = 1'b0;
        idle(4);
        check("post_rst_rd7_i0", dout[0][0], 64'h5);
        check("post_rst_rd7_i1", dout[1][0], 64'h5);
        drive(1, 8'h00, 6'd3, 64'h0, 0, 8'h00, 6'd0, 64'h0);
        idle(4);
        check("retained3_i0", dout[0][0], 64'hFFFF_FFFF_FFFF_FFFF);
        check("retained3_i1", dout[1][0], 64'hFFFF_FFFF_FFFF_FFFF);

        for (int c = 0; c < 1200; c++) begin
            rst    = ($urandom_range(0, 79) == 0);
            a_en   = ($urandom_range(0, 3) != 0);
            a_addr = pick_addr();
            a_we   = pick_we();
            a_wd   = {$urandom, $urandom};
            b_en   = ($urandom_range(0, 3) != 0);
            b_addr = pick_addr();
            b_we   = pick_we();
            b_wd   = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
        rst = 1'b0; a_en = 1'b0; b_en = 1'b0;
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
